// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed 89-tap lowpass FIR:
// sizes, FSM state type, default coefficient bank and index helpers.
package fir_pkg;

  localparam int TAPS = 89;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int FRAC = 14;
  localparam int AW   = 7;
  localparam int ACCW = DW + CW + AW + 1;
  localparam int PW   = DW + CW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default symmetric lowpass set (Q1.14); zero crossings at taps 19/69,
  // window tails forced to zero at taps 0/1/87/88.
  localparam logic signed [CW-1:0] COEF_DEFAULT [TAPS] = '{
    16'sd0,    16'sd0,    16'sd0,   -16'sd1,   -16'sd1,   -16'sd3,   -16'sd5,   -16'sd7,   -16'sd9,
   -16'sd12,  -16'sd14,  -16'sd17,  -16'sd19,  -16'sd21,  -16'sd21,  -16'sd21,  -16'sd19,  -16'sd15,
   -16'sd9,    16'sd0,    16'sd11,   16'sd25,   16'sd42,   16'sd62,   16'sd85,   16'sd111,  16'sd140,
    16'sd171,  16'sd205,  16'sd241,  16'sd278,  16'sd317,  16'sd355,  16'sd394,  16'sd432,  16'sd469,
    16'sd504,  16'sd537,  16'sd567,  16'sd593,  16'sd614,  16'sd632,  16'sd645,  16'sd652,  16'sd655,
    16'sd652,  16'sd645,  16'sd632,  16'sd614,  16'sd593,  16'sd567,  16'sd537,  16'sd504,  16'sd469,
    16'sd432,  16'sd394,  16'sd355,  16'sd317,  16'sd278,  16'sd241,  16'sd205,  16'sd171,  16'sd140,
    16'sd111,  16'sd85,   16'sd62,   16'sd42,   16'sd25,   16'sd11,   16'sd0,   -16'sd9,   -16'sd15,
   -16'sd19,  -16'sd21,  -16'sd21,  -16'sd21,  -16'sd19,  -16'sd17,  -16'sd14,  -16'sd12,  -16'sd9,
   -16'sd7,   -16'sd5,   -16'sd3,   -16'sd1,   -16'sd1,    16'sd0,    16'sd0,    16'sd0
  };

  // (base - k) mod TAPS; TAPS is not a power of two so the wrap is explicit.
  // When base < k the true result base+TAPS-k lies in 1..TAPS-1, so the
  // AW-bit intermediate wrap cancels out.
  function automatic logic [AW-1:0] tap_index(input logic [AW-1:0] base,
                                               input logic [AW-1:0] k);
    if (base >= k) begin
      return base - k;
    end else begin
      return base + AW'(TAPS) - k;
    end
  endfunction

  // Circular write-pointer advance, TAPS-1 wraps to 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(TAPS - 1)) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

endpackage

// File: rtl/fir_tdm_sequencer_if.sv
// Sample/coefficient/result bundle between the FIR sequencer and its user.
interface fir_tdm_sequencer_if;
  import fir_pkg::*;

  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 busy;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/fir_tap_mac.sv
// Shared multiply-accumulate for the FIR plus the round-half-up,
// arithmetic-shift and saturate stage. res_o reflects the value the
// accumulator takes on the coming edge, so the last tap's product is
// already included when the sequencer captures the result.
module fir_tap_mac
  import fir_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic signed [DW-1:0] samp_i,
  output logic signed [DW-1:0] res_o
);

  localparam logic signed [ACCW-1:0] RND_BIAS = ACCW'(2 ** (FRAC - 1));
  localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'(2 ** (DW - 1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN  = ~SAT_MAX;

  logic signed [PW-1:0]   prod_s;
  logic signed [ACCW-1:0] acc_d;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] biased_s;
  logic signed [ACCW-1:0] shifted_s;

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    prod_s = PW'(coef_i) * PW'(samp_i);
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACCW'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Round half up, drop fractional bits, clamp to the output range.
  always_comb begin
    biased_s  = acc_d + RND_BIAS;
    shifted_s = biased_s >>> FRAC;
    if (shifted_s > SAT_MAX) begin
      res_o = SAT_MAX[DW-1:0];
    end else if (shifted_s < SAT_MIN) begin
      res_o = SAT_MIN[DW-1:0];
    end else begin
      res_o = shifted_s[DW-1:0];
    end
  end

endmodule

// File: rtl/fir_tdm_sequencer.sv
// 89-tap FIR controller: one sample per handshake into a circular delay
// line, then TAPS cycles on the shared MAC, then one registered result.
// Owns the run-time writable coefficient bank.
module fir_tdm_sequencer
  import fir_pkg::*;
(
  input logic                clock_50,
  input logic                reset_n,
  fir_tdm_sequencer_if.slave bus
);

  state_e               state_q;
  logic [AW-1:0]        wptr_q;
  logic [AW-1:0]        base_q;
  logic [AW-1:0]        k_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 out_valid_q;
  logic signed [DW-1:0] out_data_q;
  logic signed [DW-1:0] dly_q  [TAPS];
  logic signed [CW-1:0] coef_q [TAPS];

  logic                 accept_s;
  logic                 coef_wr_s;
  logic                 mac_en_s;
  logic [AW-1:0]        rd_idx_s;
  logic signed [DW-1:0] mac_res_s;

  assign accept_s  = bus.in_valid && (state_q == ST_IDLE);
  assign coef_wr_s = bus.coef_we && (state_q == ST_IDLE) && (bus.coef_addr < AW'(TAPS));
  assign mac_en_s  = (state_q == ST_MAC);
  assign rd_idx_s  = tap_index(base_q, k_q);

  fir_tap_mac u_mac (
    .clk_i  (clock_50),
    .rst_ni (reset_n),
    .clr_i  (accept_s),
    .en_i   (mac_en_s),
    .coef_i (coef_q[k_q]),
    .samp_i (dly_q[rd_idx_s]),
    .res_o  (mac_res_s)
  );

  // Sequencing FSM with its registered handshake and result outputs.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      base_q      <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_q <= 1'b0;
          if (accept_s) begin
            base_q     <= wptr_q;
            wptr_q     <= ptr_inc(wptr_q);
            k_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (k_q == AW'(TAPS - 1)) begin
            out_data_q  <= mac_res_s;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        ST_DONE: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Delay line: the accepted sample lands at the current write pointer.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i] <= '0;
      end
    end else if (accept_s) begin
      dly_q[wptr_q] <= bus.in_data;
    end
  end

  // Coefficient bank: writes only while idle and only to valid taps.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= COEF_DEFAULT[i];
      end
    end else if (coef_wr_s) begin
      coef_q[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Self-checking bench for fir_tdm_sequencer. Expected results come from a
// sample-history model: y = sat(round(sum_k coef[k] * x[n-k] / 2^14)).
module tb_fir_tdm_sequencer;

  localparam int NT = 89;

  logic clock_50;
  logic reset_n;

  fir_tdm_sequencer_if bus ();

  fir_tdm_sequencer dut (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  // First half (taps 0..44) of the default lowpass table; the rest mirrors.
  int half [45] = '{0, 0, 0, -1, -1, -3, -5, -7, -9, -12,
                    -14, -17, -19, -21, -21, -21, -19, -15, -9, 0,
                    11, 25, 42, 62, 85, 111, 140, 171, 205, 241,
                    278, 317, 355, 394, 432, 469, 504, 537, 567, 593,
                    614, 632, 645, 652, 655};

  int mcoef [NT];
  int hist [$];
  int expq [$];
  int n_vec = 0;
  int n_err = 0;

  logic signed [15:0] got;
  int cyc, last_acc, n_acc, xs, n_ov, wa, wv;

  function automatic int dflt(input int k);
    return half[(k <= 44) ? k : (88 - k)];
  endfunction

  function automatic int model_out();
    longint s = 0;
    for (int k = 0; k < NT; k++) begin
      if (k < hist.size()) s += longint'(mcoef[k]) * longint'(hist[hist.size() - 1 - k]);
    end
    s = (s + 64'sd8192) >>> 14;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  function automatic int rand16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < NT; k++) mcoef[k] = dflt(k);
  endtask

  task automatic hist_push(input int x);
    hist.push_back(x);
    if (hist.size() > NT) hist.delete(0);
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where in_ready is seen high.
  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clock_50);
      n++;
    end
    check("ready_wait", bus.in_ready, 1);
  endtask

  task automatic write_coef(input int addr, input int val);
    wait_ready();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 7'(addr);
    bus.coef_wdata = 16'(val);
    @(posedge clock_50);
    if (addr < NT) mcoef[addr] = val;
    @(negedge clock_50);
    bus.coef_we = 1'b0;
  endtask

  // One sample through the filter, optionally with a same-edge coefficient write.
  task automatic send(input int x, input bit we, input int waddr, input int wval,
                      output logic signed [15:0] res);
    int lat;
    int exp_v;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(x);
    if (we) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = 7'(waddr);
      bus.coef_wdata = 16'(wval);
    end
    @(posedge clock_50);
    if (we && waddr < NT) mcoef[waddr] = wval;
    hist_push(x);
    exp_v = model_out();
    @(negedge clock_50);
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    check("accept_busy", bus.busy, 1);
    check("accept_ready", bus.in_ready, 0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clock_50);
      lat++;
      @(negedge clock_50);
    end
    // Strobe is driven after edge E0+89 and captured downstream at E0+90.
    check("latency_edges", lat, NT);
    res = bus.out_data;
    check("out_data", res, exp_v);
    @(negedge clock_50);
    check("strobe_one_cycle", bus.out_valid, 0);
    check("ready_after_strobe", bus.in_ready, 1);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    model_reset();

    // Reset values.
    repeat (3) @(negedge clock_50);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    @(negedge clock_50);

    // Impulse against default coefficients reproduces the table.
    for (int n = 0; n < NT; n++) begin
      send((n == 0) ? 16384 : 0, 1'b0, 0, 0, got);
      check("impulse_tap", got, dflt(n));
    end

    // Saturation: single tap at full scale.
    write_coef(0, 32767);
    for (int a = 1; a < NT; a++) write_coef(a, 0);
    send(32767, 1'b0, 0, 0, got);
    check("sat_pos", got, 32767);
    send(-32768, 1'b0, 0, 0, got);
    check("sat_neg", got, -32768);

    // Rounding: single tap with weight 1 LSB.
    write_coef(0, 1);
    send(8192, 1'b0, 0, 0, got);
    check("rnd_8192", got, 1);
    send(8191, 1'b0, 0, 0, got);
    check("rnd_8191", got, 0);
    send(-8193, 1'b0, 0, 0, got);
    check("rnd_m8193", got, -1);
    send(-8192, 1'b0, 0, 0, got);
    check("rnd_m8192", got, 0);

    // Handshake: in_valid held high; a coefficient write during MAC is dropped.
    xs = int'($urandom_range(1000, 30000)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(xs);
    cyc = 0;
    last_acc = -1000;
    n_acc = 0;
    while (n_acc < 3 && cyc < 400) begin
      check("hs_ready_vs_busy", bus.in_ready, !bus.busy);
      if (bus.out_valid === 1'b1) check("hs_out", bus.out_data, expq.pop_front());
      if (bus.in_ready === 1'b1) begin
        if (n_acc > 0) check("hs_spacing", cyc - last_acc, NT + 2);
        last_acc = cyc;
        n_acc++;
        hist_push(xs);
        expq.push_back(model_out());
      end
      bus.coef_we    = (cyc == last_acc + 20);
      bus.coef_addr  = '0;
      bus.coef_wdata = 16'sd12345;
      @(posedge clock_50);
      cyc++;
      @(negedge clock_50);
      if (cyc == last_acc + 1) begin
        xs = int'($urandom_range(1000, 30000)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
        bus.in_data = 16'(xs);
      end
    end
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    check("hs_accepts", n_acc, 3);
    cyc = 0;
    while (expq.size() > 0 && cyc < 300) begin
      if (bus.out_valid === 1'b1) check("hs_out", bus.out_data, expq.pop_front());
      @(negedge clock_50);
      cyc++;
    end
    check("hs_drained", expq.size(), 0);

    // Reset pulse 40 cycles into MAC aborts the computation.
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd12345;
    @(posedge clock_50);
    @(negedge clock_50);
    bus.in_valid = 1'b0;
    repeat (40) @(posedge clock_50);
    #3 reset_n = 1'b0;
    model_reset();
    @(negedge clock_50);
    check("abort_busy", bus.busy, 0);
    check("abort_out_data", bus.out_data, 0);
    repeat (2) @(negedge clock_50);
    reset_n = 1'b1;
    n_ov = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock_50);
      if (bus.out_valid !== 1'b0) n_ov++;
    end
    check("abort_no_strobe", n_ov, 0);
    check("abort_ready", bus.in_ready, 1);
    for (int n = 0; n < NT; n++) begin
      send((n == 0) ? 16384 : 0, 1'b0, 0, 0, got);
      check("impulse2_tap", got, dflt(n));
    end

    // Random regression with pointer wrap and three coefficient rewrites.
    for (int i = 0; i < 300; i++) begin
      if (i == 60) write_coef(int'($urandom_range(0, 88)), rand16());
      if (i == 150) write_coef(int'($urandom_range(89, 127)), rand16());
      if (i == 240) begin
        wa = int'($urandom_range(0, 88));
        wv = rand16();
        send(rand16(), 1'b1, wa, wv, got);
      end else begin
        send(rand16(), 1'b0, 0, 0, got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
